crcu_apb_rst_regs: RTL and testbench

//  APB3 slave register file for the CRCU reset-control registers. It produces the per-domain
//  32-bit rst_ctl_reg words consumed by the VPU/peer reset-control stages:
//  bit0 enable, bit1 async, bit2 polarity (1=posedge), bit3 sw_pulse.

---
 rtl/crcu_pkg.sv | 28 ++
 rtl/crcu_rst_pulse_timer.sv | 29 ++
 rtl/crcu_apb_rst_regs.sv | 152 +++++++++++++++
 tb/tb_crcu_apb_rst_regs.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crcu_pkg.sv
// Shared constants, FSM state type and captured-request payload for the CRCU
// reset-control APB register file.
package crcu_pkg;

    localparam int unsigned APB_AW = 8;
    localparam int unsigned APB_DW = 32;

    localparam int unsigned CTL_EN_BIT    = 0;
    localparam int unsigned CTL_ASYNC_BIT = 1;
    localparam int unsigned CTL_POL_BIT   = 2;
    localparam int unsigned CTL_PULSE_BIT = 3;

    localparam logic [APB_AW-1:0] ADDR_STATUS = 8'hF8;
    localparam logic [APB_AW-1:0] ADDR_LOCK   = 8'hFC;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/crcu_rst_pulse_timer.sv
// Software reset pulse timer: a load holds active high for exactly PULSE_CYCLES
// cycles, and a reload while running restarts the full count.
module crcu_rst_pulse_timer #(
    parameter int unsigned PULSE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active
);

    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt;

    // Load takes priority over the decrement so a reload at count 1 never gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(PULSE_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign active = (cnt != '0);

endmodule

// File: rtl/crcu_apb_rst_regs.sv
// APB3 slave holding the per-domain reset-control words, with write-lock key,
// programmable wait states and self-timing software reset pulses.
module crcu_apb_rst_regs
    import crcu_pkg::*;
#(
    parameter int unsigned NUM_RST      = 4,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned PULSE_CYCLES = 16,
    parameter logic [31:0] LOCK_KEY     = 32'hC0DE_A55A
) (
    input  logic                   CRCU_CLK,
    input  logic                   CRCU_RST,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [APB_AW-1:0]      paddr,
    input  logic [APB_DW-1:0]      pwdata,
    output logic [APB_DW-1:0]      prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [NUM_RST*32-1:0]  rst_ctl_reg
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned STAT_N = (NUM_RST < APB_DW) ? NUM_RST : APB_DW;

    apb_state_e                   state, state_next;
    logic [CNT_W-1:0]             cnt;
    apb_req_t                     req_q;
    logic [NUM_RST-1:0][2:0]      ctl_q;
    logic                         locked;
    logic [NUM_RST-1:0]           pulse_load, pulse_active;
    logic [NUM_RST-1:0][31:0]     ctl_word;
    logic [IDX_W-1:0]             idx;
    logic                         setup_req, ctl_hit, is_status, is_lock, err, commit;
    logic [APB_DW-1:0]            rdata, status_word;

    assign setup_req = psel & ~penable;

    // Address decode and error classification of the captured request.
    always_comb begin
        idx       = req_q.addr[7:2];
        ctl_hit   = 32'(idx) < NUM_RST;
        is_status = (req_q.addr == ADDR_STATUS);
        is_lock   = (req_q.addr == ADDR_LOCK);
        err       = (req_q.addr[1:0] != 2'b00)
                  | ~(ctl_hit | is_status | is_lock)
                  | (req_q.write & is_status)
                  | (req_q.write & ctl_hit & locked);
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_N-1:0] = pulse_active[STAT_N-1:0];
        rdata = '0;
        for (int i = 0; i < NUM_RST; i++) begin
            ctl_word[i]                = '0;
            ctl_word[i][CTL_EN_BIT]    = ctl_q[i][0];
            ctl_word[i][CTL_ASYNC_BIT] = ctl_q[i][1];
            ctl_word[i][CTL_POL_BIT]   = ctl_q[i][2];
            ctl_word[i][CTL_PULSE_BIT] = pulse_active[i];
            if (idx == IDX_W'(i)) begin
                rdata = ctl_word[i];
            end
        end
        if (is_lock) begin
            rdata = {31'b0, locked};
        end else if (is_status) begin
            rdata = status_word;
        end
    end

    assign rst_ctl_reg = ctl_word;

    always_comb begin
        state_next = state;
        pready     = (state == ACCESS) && (cnt == CNT_W'(WAIT_STATES));
        pslverr    = 1'b0;
        prdata     = '0;
        commit     = 1'b0;
        pulse_load = '0;
        case (state)
            IDLE:    if (setup_req) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_next = setup_req ? SETUP : IDLE;
                end else if (!psel) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        pslverr = pready & err;
        commit  = pready & ~err & req_q.write;
        if (pready && !err && !req_q.write) begin
            prdata = rdata;
        end
        for (int i = 0; i < NUM_RST; i++) begin
            pulse_load[i] = commit & ctl_hit & (idx == IDX_W'(i)) & req_q.wdata[CTL_PULSE_BIT];
        end
    end

    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == ACCESS && state_next == ACCESS) ? cnt + CNT_W'(1) : '0;
        end
    end

    // Request is captured on entry to SETUP and held through ACCESS.
    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            req_q <= '0;
        end else if (state_next == SETUP) begin
            req_q <= '{write: pwrite, addr: paddr, wdata: pwdata};
        end
    end

    always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
        if (CRCU_RST) begin
            ctl_q  <= '0;
            locked <= 1'b1;
        end else if (commit) begin
            if (is_lock) begin
                locked <= (req_q.wdata != LOCK_KEY);
            end
            for (int i = 0; i < NUM_RST; i++) begin
                if (ctl_hit && idx == IDX_W'(i)) begin
                    ctl_q[i] <= {req_q.wdata[CTL_POL_BIT], req_q.wdata[CTL_ASYNC_BIT],
                                 req_q.wdata[CTL_EN_BIT]};
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RST; g++) begin : g_timer
        crcu_rst_pulse_timer #(
            .PULSE_CYCLES(PULSE_CYCLES)
        ) u_timer (
            .clk    (CRCU_CLK),
            .rst    (CRCU_RST),
            .load   (pulse_load[g]),
            .active (pulse_active[g])
        );
    end

endmodule

// File: tb/tb_crcu_apb_rst_regs.sv
// Scoreboard bench for crcu_apb_rst_regs: randomized APB traffic against a
// cycle-stamped behavioural model of the register map and reset pulses.
module tb_crcu_apb_rst_regs;

    localparam int unsigned NUM_RST = 4;
    localparam int unsigned WS      = 3;
    localparam int unsigned PC      = 16;
    localparam logic [31:0] KEY     = 32'hC0DE_A55A;

    logic                  CRCU_CLK, CRCU_RST;
    logic                  psel, penable, pwrite;
    logic [7:0]            paddr;
    logic [31:0]           pwdata, prdata;
    logic                  pready, pslverr;
    logic [NUM_RST*32-1:0] rst_ctl_reg;

    crcu_apb_rst_regs #(
        .NUM_RST(NUM_RST), .WAIT_STATES(WS), .PULSE_CYCLES(PC), .LOCK_KEY(KEY)
    ) dut (
        .CRCU_CLK(CRCU_CLK), .CRCU_RST(CRCU_RST), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .rst_ctl_reg(rst_ctl_reg)
    );

    initial begin
        CRCU_CLK = 1'b0;
        forever #5 CRCU_CLK = ~CRCU_CLK;
    end

    int cyc = 0;
    always @(posedge CRCU_CLK) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: control bits per domain, lock flag, pulse windows (start, end] in cycles.
    logic [2:0] m_ctl [NUM_RST];
    logic       m_locked;
    int         p_start [NUM_RST];
    int         p_end   [NUM_RST];

    function automatic void m_reset();
        for (int i = 0; i < NUM_RST; i++) begin
            m_ctl[i] = 3'b000; p_start[i] = -1; p_end[i] = -1;
        end
        m_locked = 1'b1;
    endfunction

    function automatic logic m_active(input int i, input int c);
        return (c > p_start[i]) && (c <= p_end[i]);
    endfunction

    function automatic logic [31:0] m_word(input int i, input int c);
        return {28'b0, m_active(i, c), m_ctl[i]};
    endfunction

    function automatic logic [127:0] m_vec(input int c);
        logic [127:0] v = '0;
        for (int i = 0; i < NUM_RST; i++) v[32*i +: 32] = m_word(i, c);
        return v;
    endfunction

    // Apply one transfer whose completion cycle is k; returns the expected response.
    function automatic void m_apply(input logic w, input logic [7:0] a, input logic [31:0] d,
                                    input int k, output logic [31:0] rd, output logic er);
        int   ix     = int'(a[7:2]);
        logic is_ctl = (a[1:0] == 2'b00) && (ix < NUM_RST);
        logic is_st  = (a == 8'hF8);
        logic is_lk  = (a == 8'hFC);
        logic [31:0] st = '0;
        for (int i = 0; i < NUM_RST; i++) st[i] = m_active(i, k);
        rd = '0;
        er = 1'b0;
        if (a[1:0] != 2'b00 || !(is_ctl || is_st || is_lk)) er = 1'b1;
        else if (w && is_st) er = 1'b1;
        else if (w && is_ctl && m_locked) er = 1'b1;
        else if (!w) rd = is_lk ? {31'b0, m_locked} : (is_st ? st : m_word(ix, k));
        else if (is_lk) m_locked = (d != KEY);
        else begin
            m_ctl[ix] = d[2:0];
            if (d[3]) begin
                if (!m_active(ix, k)) p_start[ix] = k;
                p_end[ix] = k + PC;
            end
        end
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    always @(negedge CRCU_CLK) begin
        exp_t e;
        if (!CRCU_RST && pready) begin
            if (sbq.size() == 0) chk("unexpected_pready", 128'(1), 128'(0));
            else begin
                e = sbq.pop_front();
                chk("prdata", 128'(prdata), 128'(e.rdata));
                chk("pslverr", 128'(pslverr), 128'(e.err));
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge CRCU_CLK); #1;
        end
    endtask

    // One APB transfer; k returns the cycle in which pready is expected.
    task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d, output int k);
        exp_t e;
        int   lows = 0;
        @(posedge CRCU_CLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        k = cyc + 2 + int'(WS);
        m_apply(w, a, d, k, e.rdata, e.err);
        sbq.push_back(e);
        @(posedge CRCU_CLK); #1;
        penable = 1'b1;
        forever begin
            @(negedge CRCU_CLK);
            if (pready) break;
            lows++;
            if (lows > 40) break;
        end
        chk("wait_states", 128'(lows), 128'(1 + WS));
        @(posedge CRCU_CLK); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        int   k, k1, k2, hi, first, last, rdy;
        logic [7:0]  a;
        logic [31:0] d;
        logic        w;

        CRCU_RST = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        m_reset();
        repeat (3) @(posedge CRCU_CLK);
        @(negedge CRCU_CLK);
        chk("reset_ctl", rst_ctl_reg, 128'(0));
        chk("reset_pready", 128'(pready), 128'(0));
        chk("reset_pslverr", 128'(pslverr), 128'(0));
        @(posedge CRCU_CLK); #1;
        CRCU_RST = 1'b0;

        // Lock behaviour
        apb(1'b0, 8'hFC, 32'h0, k);
        apb(1'b1, 8'h00, 32'h7, k);
        chk("locked_ctl0", rst_ctl_reg, m_vec(cyc));
        apb(1'b1, 8'hFC, KEY, k);
        apb(1'b1, 8'h00, 32'h7, k);
        chk("unlocked_ctl0_bits", 128'(rst_ctl_reg[2:0]), 128'(3'b111));
        apb(1'b0, 8'h00, 32'h0, k);

        // Single pulse on domain 2
        apb(1'b1, 8'h08, 32'h8, k1);
        hi = 0;
        repeat (25) begin
            @(negedge CRCU_CLK);
            if (rst_ctl_reg[64+3]) hi++;
        end
        chk("pulse_len_single", 128'(hi), 128'(PC));

        // Pulse on domain 1 re-armed as its counter reaches 1
        apb(1'b1, 8'h04, 32'h8, k1);
        hi = 0; first = -1; last = -1;
        fork
            begin
                wait_to(k1 + int'(PC) - 2 - int'(WS) - 1);
                apb(1'b1, 8'h04, 32'h8, k2);
                apb(1'b0, 8'hF8, 32'h0, k);
            end
            begin
                repeat (45) begin
                    @(negedge CRCU_CLK);
                    if (rst_ctl_reg[32+3]) begin
                        hi++;
                        if (first < 0) first = cyc;
                        last = cyc;
                    end
                end
            end
        join
        chk("pulse_len_rearm", 128'(hi), 128'(2 * PC));
        chk("pulse_first", 128'(first), 128'(k1 + 1));
        chk("pulse_contig", 128'(last - first + 1), 128'(hi));

        // Error cases
        apb(1'b0, 8'h02, 32'h0, k);
        apb(1'b1, 8'h40, 32'h5, k);
        apb(1'b0, 8'h40, 32'h0, k);
        apb(1'b1, 8'hF8, 32'hF, k);
        chk("err_no_change", rst_ctl_reg, m_vec(cyc));

        // psel dropped during ACCESS: no commit, no pready
        @(posedge CRCU_CLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h5;
        @(posedge CRCU_CLK); #1;
        penable = 1'b1;
        @(posedge CRCU_CLK); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rdy = 0;
        repeat (8) begin
            @(negedge CRCU_CLK);
            if (pready) rdy++;
        end
        chk("abort_no_pready", 128'(rdy), 128'(0));
        chk("abort_no_commit", rst_ctl_reg, m_vec(cyc));

        // Randomized back-to-back traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 8'(4 * $urandom_range(0, NUM_RST - 1));
                4:          a = 8'hF8;
                5:          a = 8'hFC;
                6:          a = 8'(4 * $urandom_range(0, NUM_RST - 1) + $urandom_range(1, 3));
                7:          a = 8'(4 * $urandom_range(NUM_RST, 61));
                default:    a = 8'(4 * $urandom_range(0, NUM_RST - 1));
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 8'hFC && $urandom_range(0, 2) != 0) d = KEY;
            apb(w, a, d, k);
            chk("rand_ctl_vec", rst_ctl_reg, m_vec(cyc));
        end

        // Reset in the middle of an unlocked CTL write
        apb(1'b1, 8'hFC, KEY, k);
        apb(1'b1, 8'h00, 32'h0, k);
        @(posedge CRCU_CLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h7;
        @(posedge CRCU_CLK); #1;
        penable = 1'b1;
        @(posedge CRCU_CLK); #1;
        CRCU_RST = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        m_reset();
        @(negedge CRCU_CLK);
        chk("rst_mid_pready", 128'(pready), 128'(0));
        @(posedge CRCU_CLK); #1;
        CRCU_RST = 1'b0;
        @(negedge CRCU_CLK);
        chk("rst_mid_ctl", rst_ctl_reg, 128'(0));
        apb(1'b0, 8'hFC, 32'h0, k);
        apb(1'b1, 8'h00, 32'h7, k);
        chk("rst_mid_relocked", rst_ctl_reg, m_vec(cyc));

        repeat (5) @(posedge CRCU_CLK);
        chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
